// File: rtl/fifo_lane_unpacker_if.sv
// Handshake bundle between the CDC FIFO peek port, the lane unpacker and the lane sink.
// The unpacker sits on the slave side; the FIFO/sink environment drives the master side.
interface fifo_lane_unpacker_if #(
  parameter int DataWidth = 32,
  parameter int LaneWidth = 8
);
  logic                 DataValid_In;
  logic [DataWidth-1:0] DataIn;
  logic                 Deq_Out;
  logic                 Flush;
  logic                 LaneValid;
  logic                 LaneReady;
  logic [LaneWidth-1:0] LaneData;
  logic                 LaneFirst;
  logic                 LaneLast;
  logic [15:0]          WordCount;

  modport master (
    output DataValid_In, DataIn, Flush, LaneReady,
    input  Deq_Out, LaneValid, LaneData, LaneFirst, LaneLast, WordCount
  );

  modport slave (
    input  DataValid_In, DataIn, Flush, LaneReady,
    output Deq_Out, LaneValid, LaneData, LaneFirst, LaneLast, WordCount
  );
endinterface

// File: rtl/fifo_lane_unpacker.sv
// Dequeues wide FIFO words and replays them as narrow lanes on a valid/ready stream,
// one lane per cycle with the next word loaded on the last-lane handshake.

module fifo_lane_unpacker_lane #(
  parameter int LaneWidth = 8,
  parameter int IdxW      = 2,
  parameter int Index     = 0
) (
  input  logic [LaneWidth-1:0] slice_i,
  input  logic [IdxW-1:0]      sel_i,
  input  logic                 en_i,
  output logic [LaneWidth-1:0] lane_o
);
  assign lane_o = (en_i && (sel_i == IdxW'(Index))) ? slice_i : '0;
endmodule

module fifo_lane_unpacker #(
  parameter int DataWidth = 32,
  parameter int LaneWidth = 8,
  parameter bit MsbFirst  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_lane_unpacker_if.slave  bus
);
  localparam int Ratio = DataWidth / LaneWidth;
  localparam int IdxW  = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Ratio - 1);

  if ((DataWidth % LaneWidth) != 0) begin : g_bad_width
    $error("fifo_lane_unpacker: DataWidth must be a multiple of LaneWidth");
  end
  if (Ratio < 2) begin : g_bad_ratio
    $error("fifo_lane_unpacker: DataWidth/LaneWidth must be at least 2");
  end

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_e;

  state_e                         state_q, state_d;
  logic [Ratio-1:0][LaneWidth-1:0] word_q, word_d;
  logic [IdxW-1:0]                idx_q, idx_d, sel_d;
  logic [15:0]                    cnt_q, cnt_d;
  logic [LaneWidth-1:0]           data_q, data_d;
  logic                           first_q, first_d, last_q, last_d;
  logic                           loaded, hold_d, last_hs, load_en;
  logic [Ratio-1:0][LaneWidth-1:0] lane_pick;

  assign loaded = (state_q == HOLD);

  // Flush wins over load, lane advance and word counting.
  always_comb begin
    last_hs = loaded & bus.LaneReady & (idx_q == LastIdx);
    load_en = bus.DataValid_In & ~bus.Flush & (~loaded | last_hs);
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (bus.Flush) begin
      state_d = EMPTY;
      idx_d   = '0;
    end else begin
      if (load_en) begin
        word_d  = bus.DataIn;
        state_d = HOLD;
        idx_d   = '0;
      end else if (last_hs) begin
        state_d = EMPTY;
        idx_d   = '0;
      end else if (loaded & bus.LaneReady) begin
        idx_d = idx_q + 1'b1;
      end
      if (last_hs) cnt_d = cnt_q + 16'd1;
    end
  end

  // Lane outputs are registered from next-state so a stalled lane stays put for free.
  always_comb begin
    hold_d  = (state_d == HOLD);
    sel_d   = MsbFirst ? (LastIdx - idx_d) : idx_d;
    first_d = hold_d & (idx_d == '0);
    last_d  = hold_d & (idx_d == LastIdx);
  end

  for (genvar i = 0; i < Ratio; i++) begin : g_lane
    fifo_lane_unpacker_lane #(
      .LaneWidth (LaneWidth),
      .IdxW      (IdxW),
      .Index     (i)
    ) u_lane (
      .slice_i (word_d[i]),
      .sel_i   (sel_d),
      .en_i    (hold_d),
      .lane_o  (lane_pick[i])
    );
  end

  always_comb begin
    data_d = '0;
    for (int i = 0; i < Ratio; i++) data_d = data_d | lane_pick[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign bus.Deq_Out   = load_en & rst_n;
  assign bus.LaneValid = loaded;
  assign bus.LaneData  = data_q;
  assign bus.LaneFirst = first_q;
  assign bus.LaneLast  = last_q;
  assign bus.WordCount = cnt_q;
endmodule
